// File: rtl/mult_cdb_buffer.sv
// mult_cdb_buffer: multiplier result FIFO, op delay line and CDB request; define MULT_CDB_BYPASS_EN for same-cycle bypass
package common;
  localparam int ROB_WIDTH = 4;
  localparam int PRF_WIDTH = 6;
endpackage

module mult_cdb_buffer
  import common::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_STAGE = 4,
  parameter int DEPTH     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_start,
  input  logic                      issue_hi_sel,
  input  logic [ROB_WIDTH:0]        issue_rob_id,
  output logic                      credit_ok,
  input  logic                      mult_done,
  input  logic                      mult_valid,
  input  logic [2*XLEN-1:0]         mult_product,
  input  logic [ROB_WIDTH:0]        mult_rob_id,
  input  logic [PRF_WIDTH-1:0]      mult_prf_id,
  input  logic                      flush_valid,
  input  logic [ROB_WIDTH:0]        flush_robid,
  output logic                      cdb_req,
  input  logic                      cdb_grant,
  output logic [XLEN-1:0]           cdb_data,
  output logic [ROB_WIDTH:0]        cdb_rob_id,
  output logic [PRF_WIDTH-1:0]      cdb_prf_id,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int RW = ROB_WIDTH + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(DEPTH + NUM_STAGE) + 1;
  localparam int L  = NUM_STAGE - 1;

  function automatic logic younger(input logic [RW-1:0] x, input logic [RW-1:0] f);
    return x[RW-1] ^ f[RW-1] ^ (x[RW-2:0] > f[RW-2:0]);
  endfunction

  logic [NUM_STAGE-1:0] r_dl_v, r_dl_hi, w_dl_v_in;
  logic [RW-1:0]        r_dl_rob [NUM_STAGE];
  logic [RW-1:0]        w_dl_rob_in [NUM_STAGE];
  logic [SW-1:0]        w_inflight;

  logic [DEPTH-1:0]     r_v;
  logic [XLEN-1:0]      r_data [DEPTH];
  logic [RW-1:0]        r_rob [DEPTH];
  logic [PRF_WIDTH-1:0] r_prf [DEPTH];
  logic [AW-1:0]        r_rd, r_wr;
  logic [CW-1:0]        r_count;

  logic            w_cap, w_byp, w_head_req, w_push, w_pop, w_full, w_wr_ok;
  logic [XLEN-1:0] w_sel;

  assign w_dl_v_in = {r_dl_v[NUM_STAGE-2:0], issue_start};

  always_comb begin
    w_dl_rob_in[0] = issue_rob_id;
    for (int i = 1; i < NUM_STAGE; i++) w_dl_rob_in[i] = r_dl_rob[i-1];
  end

  always_ff @(posedge clock) begin
    r_dl_rob <= w_dl_rob_in;
    r_dl_hi  <= {r_dl_hi[NUM_STAGE-2:0], issue_hi_sel};
    if (reset) r_dl_v <= '0;
    else
      for (int i = 0; i < NUM_STAGE; i++)
        r_dl_v[i] <= w_dl_v_in[i] & ~(flush_valid & younger(w_dl_rob_in[i], flush_robid));
  end

  // Killed FIFO entries still hold a slot until dropped, so they stay in the credit sum.
  assign w_inflight = SW'($countones(r_dl_v));
  assign credit_ok  = (SW'(r_count) + w_inflight) < SW'(DEPTH);
  assign count      = r_count;

  assign w_cap      = r_dl_v[L] & mult_done & mult_valid & ~(flush_valid & younger(mult_rob_id, flush_robid));
  assign w_sel      = r_dl_hi[L] ? mult_product[2*XLEN-1:XLEN] : mult_product[XLEN-1:0];
  assign w_head_req = r_v[r_rd] & ~(flush_valid & younger(r_rob[r_rd], flush_robid));
`ifdef MULT_CDB_BYPASS_EN
  assign w_byp = w_cap & ~|r_v;
`else
  assign w_byp = 1'b0;
`endif

  assign cdb_req    = w_head_req | w_byp;
  assign cdb_data   = w_byp ? w_sel       : w_head_req ? r_data[r_rd] : '0;
  assign cdb_rob_id = w_byp ? mult_rob_id : w_head_req ? r_rob[r_rd]  : '0;
  assign cdb_prf_id = w_byp ? mult_prf_id : w_head_req ? r_prf[r_rd]  : '0;

  assign w_push  = w_cap & ~(w_byp & cdb_grant);
  assign w_pop   = (r_count != '0) & (~r_v[r_rd] | (w_head_req & cdb_grant));
  assign w_full  = r_count == CW'(DEPTH);
  assign w_wr_ok = w_push & (~w_full | w_pop);

  always_ff @(posedge clock) begin
    if (w_wr_ok) begin
      r_data[r_wr] <= w_sel;
      r_rob[r_wr]  <= mult_rob_id;
      r_prf[r_wr]  <= mult_prf_id;
    end
    if (reset) begin
      r_v     <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (flush_valid & younger(r_rob[i], flush_robid)) r_v[i] <= 1'b0;
      if (w_pop) begin
        r_v[r_rd] <= 1'b0;
        r_rd      <= r_rd + AW'(1);
      end
      if (w_wr_ok) begin
        r_v[r_wr] <= 1'b1;
        r_wr      <= r_wr + AW'(1);
      end
      r_count <= r_count + CW'(w_wr_ok) - CW'(w_pop);
    end
  end

  a_credit: assert property (@(posedge clock) disable iff (reset) issue_start |-> credit_ok);
  a_align: assert property (@(posedge clock) disable iff (reset)
    r_dl_v[L] |-> (mult_done && mult_valid && mult_rob_id == r_dl_rob[L]));
  a_overflow: assert property (@(posedge clock) disable iff (reset) !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_mult_cdb_buffer.sv
// tb_mult_cdb_buffer: multiplier environment plus in-order result scoreboard for mult_cdb_buffer
module tb_mult_cdb_buffer;
  import common::*;
  localparam int RW = ROB_WIDTH + 1;
`ifdef MULT_CDB_BYPASS_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 5;
`endif

  logic                 clock = 0, reset = 1;
  logic                 issue_start = 0, issue_hi_sel = 0;
  logic [RW-1:0]        issue_rob_id = '0;
  logic                 credit_ok;
  logic                 mult_done = 0, mult_valid = 0;
  logic [63:0]          mult_product = '0;
  logic [RW-1:0]        mult_rob_id = '0;
  logic [PRF_WIDTH-1:0] mult_prf_id = '0;
  logic                 flush_valid = 0;
  logic [RW-1:0]        flush_robid = '0;
  logic                 cdb_req, cdb_grant = 0;
  logic [31:0]          cdb_data;
  logic [RW-1:0]        cdb_rob_id;
  logic [PRF_WIDTH-1:0] cdb_prf_id;
  logic [2:0]           count;

  mult_cdb_buffer dut (
    .clock(clock), .reset(reset), .issue_start(issue_start), .issue_hi_sel(issue_hi_sel),
    .issue_rob_id(issue_rob_id), .credit_ok(credit_ok), .mult_done(mult_done), .mult_valid(mult_valid),
    .mult_product(mult_product), .mult_rob_id(mult_rob_id), .mult_prf_id(mult_prf_id),
    .flush_valid(flush_valid), .flush_robid(flush_robid), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .cdb_data(cdb_data), .cdb_rob_id(cdb_rob_id), .cdb_prf_id(cdb_prf_id), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]          data;
    logic [RW-1:0]        rob;
    logic [PRF_WIDTH-1:0] prf;
  } exp_t;

  exp_t                 expq[$];
  bit                   mp_d [4];
  bit                   mp_v [4];
  bit   [63:0]          mp_p [4];
  bit   [RW-1:0]        mp_r [4];
  bit   [PRF_WIDTH-1:0] mp_f [4];
  logic [31:0]          op_a = '0, op_b = '0;
  logic [PRF_WIDTH-1:0] op_prf = '0;
  int                   total = 0, bad = 0, delivered = 0;
  bit                   obs_req;
  logic [31:0]          obs_data;
  logic [2:0]           obs_count;

  function automatic bit yng(input logic [RW-1:0] x, input logic [RW-1:0] f);
    return x[RW-1] ^ f[RW-1] ^ (x[RW-2:0] > f[RW-2:0]);
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit hi,
                       input logic [RW-1:0] rob, input logic [PRF_WIDTH-1:0] prf);
    issue_start = 1; issue_hi_sel = hi; issue_rob_id = rob; op_a = a; op_b = b; op_prf = prf;
  endtask

  task automatic tick();
    bit [63:0] p;
    exp_t keep[$];
    mult_done = mp_d[3]; mult_valid = mp_v[3]; mult_product = mp_p[3];
    mult_rob_id = mp_r[3]; mult_prf_id = mp_f[3];
    #1;
    obs_req = cdb_req; obs_data = cdb_data; obs_count = count;
    if (cdb_req) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL cdb_unexpected got rob=%0d data=%h, nothing pending", cdb_rob_id, cdb_data);
      end else begin
        if ({cdb_data, cdb_rob_id, cdb_prf_id} !== {expq[0].data, expq[0].rob, expq[0].prf}) begin
          bad++;
          $display("FAIL cdb_payload got data=%h rob=%0d prf=%0d want data=%h rob=%0d prf=%0d",
                   cdb_data, cdb_rob_id, cdb_prf_id, expq[0].data, expq[0].rob, expq[0].prf);
        end
        if (cdb_grant) begin
          void'(expq.pop_front());
          delivered++;
        end
      end
    end
    @(posedge clock);
    for (int i = 3; i > 0; i--) begin
      mp_d[i] = mp_d[i-1]; mp_v[i] = mp_v[i-1]; mp_p[i] = mp_p[i-1]; mp_r[i] = mp_r[i-1]; mp_f[i] = mp_f[i-1];
    end
    p = 64'(op_a) * 64'(op_b);
    mp_d[0] = issue_start; mp_v[0] = issue_start; mp_p[0] = p; mp_r[0] = issue_rob_id; mp_f[0] = op_prf;
    if (issue_start) expq.push_back('{issue_hi_sel ? p[63:32] : p[31:0], issue_rob_id, op_prf});
    if (flush_valid) begin
      for (int i = 0; i < 4; i++) if (yng(mp_r[i], flush_robid)) mp_v[i] = 0;
      foreach (expq[i]) if (!yng(expq[i].rob, flush_robid)) keep.push_back(expq[i]);
      expq = keep;
    end
    if (reset) expq.delete();
    #1;
    issue_start = 0; flush_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", cdb_req); end
    total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL reset_credit got=%b want=1", credit_ok); end
    total++; if (cdb_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", cdb_data); end
    total++; if (cdb_rob_id !== '0) begin bad++; $display("FAIL reset_rob got=%0d want=0", cdb_rob_id); end
    total++; if (cdb_prf_id !== '0) begin bad++; $display("FAIL reset_prf got=%0d want=0", cdb_prf_id); end
  endtask

  task automatic test_latency(input string nm, input logic [31:0] a, input logic [31:0] b,
                              input bit hi, input logic [31:0] want);
    int first = -1, nreq = 0, d0 = delivered;
    logic [31:0] d = '0;
    logic [2:0]  c = '0;
    cdb_grant = 1;
    issue(a, b, hi, 5, 9);
    tick();
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (obs_req) begin
        nreq++;
        if (first < 0) begin first = i; d = obs_data; c = obs_count; end
      end
    end
    total++; if (first !== LAT) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, first, LAT); end
    total++; if (d !== want) begin bad++; $display("FAIL %s_data got=%h want=%h", nm, d, want); end
    total++; if (nreq !== 1) begin bad++; $display("FAIL %s_req_cycles got=%0d want=1", nm, nreq); end
    total++; if (c !== ((LAT == 4) ? 3'd0 : 3'd1)) begin bad++; $display("FAIL %s_count_at_req got=%0d want=%0d", nm, c, (LAT == 4) ? 0 : 1); end
    total++; if (delivered - d0 !== 1) begin bad++; $display("FAIL %s_delivered got=%0d want=1", nm, delivered - d0); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL %s_count_end got=%0d want=0", nm, count); end
  endtask

  task automatic test_credit();
    int acc = 0, d0;
    cdb_grant = 0;
    for (int i = 0; i < 10; i++) begin
      if (credit_ok) begin
        issue(32'(acc + 3), 32'(acc + 5), 0, RW'(10 + acc), PRF_WIDTH'(acc + 1));
        acc++;
      end
      tick();
    end
    total++; if (acc !== 4) begin bad++; $display("FAIL credit_accepted got=%0d want=4", acc); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL credit_count got=%0d want=4", count); end
    total++; if (credit_ok !== 1'b0) begin bad++; $display("FAIL credit_full got=%b want=0", credit_ok); end
    d0 = delivered;
    cdb_grant = 1;
    idle(8);
    total++; if (delivered - d0 !== 4) begin bad++; $display("FAIL credit_pops got=%0d want=4", delivered - d0); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL credit_drain_count got=%0d want=0", count); end
    total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL credit_restored got=%b want=1", credit_ok); end
  endtask

  task automatic test_flush_fifo();
    int nreq = 0, d0;
    cdb_grant = 0;
    for (int r = 2; r <= 4; r++) begin
      issue(32'(r), 32'd100, 0, RW'(r), PRF_WIDTH'(r + 30));
      tick();
    end
    idle(6);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL flushfifo_fill got=%0d want=3", count); end
    d0 = delivered;
    flush_valid = 1; flush_robid = 2;
    tick();
    cdb_grant = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_req) nreq++;
    end
    total++; if (nreq !== 1) begin bad++; $display("FAIL flushfifo_req_cycles got=%0d want=1", nreq); end
    total++; if (delivered - d0 !== 1) begin bad++; $display("FAIL flushfifo_delivered got=%0d want=1", delivered - d0); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flushfifo_count got=%0d want=0", count); end
  endtask

  task automatic test_flush_capture();
    int d0 = delivered;
    cdb_grant = 1;
    issue(32'd11, 32'd13, 0, 3, 7);
    tick();
    idle(3);
    flush_valid = 1; flush_robid = 1;
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flushcap_count got=%0d want=0", count); end
    idle(4);
    total++; if (delivered - d0 !== 0) begin bad++; $display("FAIL flushcap_delivered got=%0d want=0", delivered - d0); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL flushcap_count_late got=%0d want=0", count); end
  endtask

  task automatic test_reset_mid();
    cdb_grant = 0;
    for (int k = 0; k < 4; k++) begin
      issue(32'(k + 7), 32'd3, 0, RW'(20 + k), PRF_WIDTH'(k));
      tick();
    end
    idle(2);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL rstmid_count_before got=%0d want=2", count); end
    total++; if (credit_ok !== 1'b0) begin bad++; $display("FAIL rstmid_credit_before got=%b want=0", credit_ok); end
    reset = 1;
    tick();
    reset = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rstmid_count got=%0d want=0", count); end
    total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%b want=0", cdb_req); end
    total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL rstmid_credit got=%b want=1", credit_ok); end
    cdb_grant = 1;
    tick();
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rstmid_stale_count got=%0d want=0", count); end
    idle(4);
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rstmid_count_late got=%0d want=0", count); end
  endtask

  task automatic test_random();
    logic [RW-1:0] next_rob = '0, f;
    bit fl;
    for (int i = 0; i < 400; i++) begin
      cdb_grant = ($urandom_range(0, 3) != 0);
      if (credit_ok && $urandom_range(0, 9) < 6) begin
        issue($urandom, $urandom, 1'($urandom_range(0, 1)), next_rob, PRF_WIDTH'($urandom_range(0, 63)));
        next_rob++;
      end
      fl = ($urandom_range(0, 19) == 0);
      f  = next_rob - RW'(1) - RW'($urandom_range(0, 5));
      if (fl) begin flush_valid = 1; flush_robid = f; end
      tick();
      if (fl) next_rob = f + RW'(1);
    end
    cdb_grant = 1;
    idle(20);
    total++; if (expq.size() !== 0) begin bad++; $display("FAIL random_pending got=%0d want=0", expq.size()); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL random_count got=%0d want=0", count); end
    total++; if (credit_ok !== 1'b1) begin bad++; $display("FAIL random_credit got=%b want=1", credit_ok); end
  endtask

  initial begin
    test_reset();
    test_latency("t1", 32'd7, 32'd6, 0, 32'd42);
    idle(2);
    test_latency("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE);
    idle(2);
    test_credit();
    idle(2);
    test_flush_fifo();
    idle(2);
    test_flush_capture();
    idle(2);
    test_reset_mid();
    idle(2);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
